rs_alu_wakeup: RTL and testbench
================================

# rs_alu_wakeup

ALU reservation station: the consumer side of dispatch-stage source operand selection. Dispatch delivers each source either as resolved data (ready) or as a zero-extended RRF tag (not ready). This block buffers up to ENTRY_NUM ALU instructions and snoops two writeback buses to replace tags with data. It issues the lowest-index entry whose operands are both ready to the ALU.

## Interface

Parameters:
- ENTRY_NUM, 8, number of entries
- ENTRY_SEL, 3, log2(ENTRY_NUM)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- flush_i  in  1  kill all entries (misprediction)
- dp_we_i  in  1  dispatch write request
- dp_src1_i / dp_src2_i  in  DATA_LEN  operand data, or RRF tag in [RRF_SEL-1:0] when not ready
- dp_rdy1_i / dp_rdy2_i  in  1  operand ready
- dp_alu_op_i  in  ALU_OP_WIDTH  ALU opcode
- dp_rrftag_i  in  RRF_SEL  destination tag
- wb1_valid_i, wb2_valid_i  in  1  writeback valid
- wb1_rrftag_i, wb2_rrftag_i  in  RRF_SEL  writeback tag
- wb1_data_i, wb2_data_i  in  DATA_LEN  writeback data
- issue_ready_i  in  1  ALU accepts this cycle
- issue_valid_o  out  1  an entry is issuable
- issue_src1_o / issue_src2_o  out  DATA_LEN  operands
- issue_alu_op_o  out  ALU_OP_WIDTH  opcode
- issue_rrftag_o  out  RRF_SEL  destination tag
- full_o  out  1  no free entry
- count_o  out  ENTRY_SEL+1  occupied entries

## Operation

- Per-entry state: busy, src1, rdy1, src2, rdy2, alu_op, rrftag.
- Allocate: if dp_we_i & ~full_o, write the lowest-index non-busy entry and set busy. If dp_we_i & full_o, drop the request and change no state. Dispatch must not do this; the bench flags it.
- Wakeup, each busy entry, each operand with rdy=0: wbN_valid_i & (src[RRF_SEL-1:0]==wbN_rrftag_i) sets rdy and writes src=wbN_data_i.
  - If both buses match, wb1 wins.
- Dispatch bypass: an operand arriving with dp_rdyX_i=0 whose tag matches a valid writeback in the same cycle is stored as ready with the writeback data.
- Select: the lowest-index entry with busy & rdy1 & rdy2.
  - issue_valid_o is combinational from the registered state.
  - issue_* outputs carry that entry's fields. They are all-zero when issue_valid_o=0.
- Release: issue_valid_o & issue_ready_i clears busy of the selected entry at the clock edge.
- Flush: clears every busy bit. It overrides allocate, wakeup and release in the same cycle.
- count_o = number of busy entries. full_o = (count_o == ENTRY_NUM).

## Timing

- Reset (reset_i=1 at a posedge): all busy=0, so issue_valid_o=0, full_o=0, count_o=0, issue_* outputs = 0. Reset takes effect on any cycle, including mid-wakeup or mid-issue; everything in flight is discarded.
- Dispatch to issue: an entry written with both operands ready can assert issue_valid_o the cycle after the write, at the earliest.
- Wakeup to issue: an operand woken at edge T is issuable from cycle T+1. There is no same-cycle wakeup-to-issue path.
- full_o and count_o reflect registered state. A release and an allocate in the same cycle:
  - are both performed;
  - leave count unchanged;
  - do not let the freed slot be reused in that cycle, since allocation uses the pre-edge busy vector.
- Issue holds while issue_ready_i=0. The selected entry can only change to a lower index that becomes ready later.
- Operand width: the tag compare uses bits [RRF_SEL-1:0] only. The upper bits of an unready src are don't-care on input and are overwritten on wakeup.

## Structure

- Shared consts file: DATA_LEN, RRF_SEL, ALU_OP_WIDTH, RS_ALU_ENT_NUM, RS_ALU_ENT_SEL.
- One sub-module, `rs_prior_enc` (ENTRY_NUM-bit lowest-set-bit priority encoder, outputs index and valid). It is instantiated twice: once for the free vector (allocation) and once for the ready vector (select).
- Per-operand wakeup is a generate loop inside the top, not a separate module.

## Test plan

- Reset, then dispatch op=ADD, src1=5 ready, src2=7 ready, tag=3, issue_ready_i=1 -> next cycle issue_valid_o=1, src1=5, src2=7, tag=3; the cycle after, count_o=0.
- Dispatch with src1 = tag 9, not ready; 2 cycles later wb2 returns tag 9, data 0xDEAD -> issue_valid_o rises one cycle after the wb, issue_src1_o=0xDEAD.
- Dispatch with src2 = tag 4, not ready, in the same cycle as wb1 tag 4, data 0x11 (bypass) -> the entry is stored ready and issues next cycle with src2=0x11.
- Fill all 8 entries with unready operands -> full_o=1, count_o=8. A 9th dp_we_i leaves state unchanged. Then release entry 2 and dispatch together -> the new instruction lands only on the following cycle, in entry 2.
- Entries 1 and 5 both ready, issue_ready_i=0 for 3 cycles -> entry 1 is held on issue_* with no release. Then issue_ready_i=1 -> entry 1 issues, then entry 5.
- flush_i asserted with 6 busy entries, plus a simultaneous dispatch and wb -> next cycle count_o=0, issue_valid_o=0.

Source files
------------

// File: rtl/rs_alu_wakeup_pkg.sv
// Shared constants, ALU opcodes and the operand snoop helper used by the
// ALU reservation station.
package rs_alu_wakeup_pkg;

    localparam int DATA_LEN       = 32;
    localparam int RRF_SEL        = 6;
    localparam int ALU_OP_WIDTH   = 4;
    localparam int RS_ALU_ENT_NUM = 8;
    localparam int RS_ALU_ENT_SEL = 3;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7,
        ALU_SLT = 4'd8
    } alu_op_e;

    // One source operand: either resolved data (rdy=1) or a tag in the low bits.
    typedef struct packed {
        logic                rdy;
        logic [DATA_LEN-1:0] data;
    } operand_t;

    // Replace an unready operand's tag with writeback data when a bus matches.
    // Bus 1 has priority over bus 2 when both carry the same tag.
    function automatic operand_t snoopOperand(
        input logic [DATA_LEN-1:0] src,
        input logic                rdy,
        input logic                wb1Valid,
        input logic [RRF_SEL-1:0]  wb1Tag,
        input logic [DATA_LEN-1:0] wb1Data,
        input logic                wb2Valid,
        input logic [RRF_SEL-1:0]  wb2Tag,
        input logic [DATA_LEN-1:0] wb2Data
    );
        operand_t res;
        res.rdy  = rdy;
        res.data = src;
        if (!rdy) begin
            if (wb1Valid && (src[RRF_SEL-1:0] == wb1Tag)) begin
                res.rdy  = 1'b1;
                res.data = wb1Data;
            end else if (wb2Valid && (src[RRF_SEL-1:0] == wb2Tag)) begin
                res.rdy  = 1'b1;
                res.data = wb2Data;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rs_alu_wakeup_prior_enc.sv
// Lowest-set-bit priority encoder: reports the index of the lowest request
// bit and whether any request is present.
module rs_prior_enc #(
    parameter int WIDTH = 8,
    parameter int SEL   = 3
) (
    input  logic [WIDTH-1:0] req_i,
    output logic [SEL-1:0]   idx_o,
    output logic             valid_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = SEL'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_alu_wakeup.sv
// ALU reservation station: buffers dispatched ALU instructions, snoops two
// writeback buses to resolve operand tags, and issues the lowest-index entry
// whose operands are both ready.
module rs_alu_wakeup
    import rs_alu_wakeup_pkg::*;
#(
    parameter int ENTRY_NUM = RS_ALU_ENT_NUM,
    parameter int ENTRY_SEL = RS_ALU_ENT_SEL
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    flush_i,
    input  logic                    dp_we_i,
    input  logic [DATA_LEN-1:0]     dp_src1_i,
    input  logic [DATA_LEN-1:0]     dp_src2_i,
    input  logic                    dp_rdy1_i,
    input  logic                    dp_rdy2_i,
    input  logic [ALU_OP_WIDTH-1:0] dp_alu_op_i,
    input  logic [RRF_SEL-1:0]      dp_rrftag_i,
    input  logic                    wb1_valid_i,
    input  logic [RRF_SEL-1:0]      wb1_rrftag_i,
    input  logic [DATA_LEN-1:0]     wb1_data_i,
    input  logic                    wb2_valid_i,
    input  logic [RRF_SEL-1:0]      wb2_rrftag_i,
    input  logic [DATA_LEN-1:0]     wb2_data_i,
    input  logic                    issue_ready_i,
    output logic                    issue_valid_o,
    output logic [DATA_LEN-1:0]     issue_src1_o,
    output logic [DATA_LEN-1:0]     issue_src2_o,
    output logic [ALU_OP_WIDTH-1:0] issue_alu_op_o,
    output logic [RRF_SEL-1:0]      issue_rrftag_o,
    output logic                    full_o,
    output logic [ENTRY_SEL:0]      count_o
);

    logic [ENTRY_NUM-1:0]    busy_q, busy_d;
    logic [DATA_LEN-1:0]     src1_q [ENTRY_NUM];
    logic [DATA_LEN-1:0]     src1_d [ENTRY_NUM];
    logic [DATA_LEN-1:0]     src2_q [ENTRY_NUM];
    logic [DATA_LEN-1:0]     src2_d [ENTRY_NUM];
    logic [ENTRY_NUM-1:0]    rdy1_q, rdy1_d;
    logic [ENTRY_NUM-1:0]    rdy2_q, rdy2_d;
    logic [ALU_OP_WIDTH-1:0] op_q [ENTRY_NUM];
    logic [ALU_OP_WIDTH-1:0] op_d [ENTRY_NUM];
    logic [RRF_SEL-1:0]      tag_q [ENTRY_NUM];
    logic [RRF_SEL-1:0]      tag_d [ENTRY_NUM];

    operand_t                wake1 [ENTRY_NUM];
    operand_t                wake2 [ENTRY_NUM];
    operand_t                dpOp1, dpOp2;

    logic [ENTRY_NUM-1:0]    freeVec, readyVec;
    logic [ENTRY_SEL-1:0]    allocIdx, selIdx;
    logic                    allocValid, selValid;
    logic                    allocEn, releaseEn;

    assign freeVec = ~busy_q;

    rs_prior_enc #(.WIDTH(ENTRY_NUM), .SEL(ENTRY_SEL)) u_alloc_enc (
        .req_i   (freeVec),
        .idx_o   (allocIdx),
        .valid_o (allocValid)
    );

    rs_prior_enc #(.WIDTH(ENTRY_NUM), .SEL(ENTRY_SEL)) u_select_enc (
        .req_i   (readyVec),
        .idx_o   (selIdx),
        .valid_o (selValid)
    );

    // Per-entry operand wakeup; only busy entries listen to the buses.
    for (genvar g = 0; g < ENTRY_NUM; g++) begin : gen_wakeup
        assign wake1[g] = snoopOperand(src1_q[g], rdy1_q[g],
                                       wb1_valid_i & busy_q[g], wb1_rrftag_i, wb1_data_i,
                                       wb2_valid_i & busy_q[g], wb2_rrftag_i, wb2_data_i);
        assign wake2[g] = snoopOperand(src2_q[g], rdy2_q[g],
                                       wb1_valid_i & busy_q[g], wb1_rrftag_i, wb1_data_i,
                                       wb2_valid_i & busy_q[g], wb2_rrftag_i, wb2_data_i);
    end

    // Dispatch bypass: an operand whose producer writes back this very cycle
    // is captured as ready instead of being stored as a stale tag.
    assign dpOp1 = snoopOperand(dp_src1_i, dp_rdy1_i,
                                wb1_valid_i, wb1_rrftag_i, wb1_data_i,
                                wb2_valid_i, wb2_rrftag_i, wb2_data_i);
    assign dpOp2 = snoopOperand(dp_src2_i, dp_rdy2_i,
                                wb1_valid_i, wb1_rrftag_i, wb1_data_i,
                                wb2_valid_i, wb2_rrftag_i, wb2_data_i);

    // Occupancy and ready vectors are derived purely from registered state.
    always_comb begin
        count_o  = '0;
        readyVec = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            count_o     = count_o + (ENTRY_SEL+1)'(busy_q[i]);
            readyVec[i] = busy_q[i] & rdy1_q[i] & rdy2_q[i];
        end
    end

    assign full_o    = (count_o == (ENTRY_SEL+1)'(ENTRY_NUM));
    assign allocEn   = dp_we_i & ~full_o & allocValid;
    assign releaseEn = selValid & issue_ready_i;
    assign issue_valid_o = selValid;

    // Issue port shows the selected entry, and all-zero when nothing is ready.
    always_comb begin
        issue_src1_o   = '0;
        issue_src2_o   = '0;
        issue_alu_op_o = '0;
        issue_rrftag_o = '0;
        if (selValid) begin
            issue_src1_o   = src1_q[selIdx];
            issue_src2_o   = src2_q[selIdx];
            issue_alu_op_o = op_q[selIdx];
            issue_rrftag_o = tag_q[selIdx];
        end
    end

    // Next-state: wakeup, then allocate into the free slot, release the issued
    // slot, and finally let flush kill every entry.
    always_comb begin
        busy_d = busy_q;
        rdy1_d = rdy1_q;
        rdy2_d = rdy2_q;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            src1_d[i] = wake1[i].data;
            rdy1_d[i] = wake1[i].rdy;
            src2_d[i] = wake2[i].data;
            rdy2_d[i] = wake2[i].rdy;
            op_d[i]   = op_q[i];
            tag_d[i]  = tag_q[i];
            if (allocEn && (allocIdx == ENTRY_SEL'(i))) begin
                busy_d[i] = 1'b1;
                src1_d[i] = dpOp1.data;
                rdy1_d[i] = dpOp1.rdy;
                src2_d[i] = dpOp2.data;
                rdy2_d[i] = dpOp2.rdy;
                op_d[i]   = dp_alu_op_i;
                tag_d[i]  = dp_rrftag_i;
            end
            if (releaseEn && (selIdx == ENTRY_SEL'(i))) begin
                busy_d[i] = 1'b0;
            end
        end
        if (flush_i) begin
            busy_d = '0;
        end
    end

    // Entry storage with synchronous reset that discards everything in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_q <= '0;
            rdy1_q <= '0;
            rdy2_q <= '0;
            for (int i = 0; i < ENTRY_NUM; i++) begin
                src1_q[i] <= '0;
                src2_q[i] <= '0;
                op_q[i]   <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            busy_q <= busy_d;
            rdy1_q <= rdy1_d;
            rdy2_q <= rdy2_d;
            for (int i = 0; i < ENTRY_NUM; i++) begin
                src1_q[i] <= src1_d[i];
                src2_q[i] <= src2_d[i];
                op_q[i]   <= op_d[i];
                tag_q[i]  <= tag_d[i];
            end
        end
    end

endmodule

// File: tb/tb_rs_alu_wakeup.sv
// Self-checking bench for the ALU reservation station: a scoreboard queue of
// expected issue packets is filled at dispatch and drained at issue.
module tb_rs_alu_wakeup;
    import rs_alu_wakeup_pkg::*;

    logic                    clk_i = 1'b0;
    logic                    reset_i, flush_i, dp_we_i, dp_rdy1_i, dp_rdy2_i;
    logic [DATA_LEN-1:0]     dp_src1_i, dp_src2_i, wb1_data_i, wb2_data_i;
    logic [ALU_OP_WIDTH-1:0] dp_alu_op_i;
    logic [RRF_SEL-1:0]      dp_rrftag_i, wb1_rrftag_i, wb2_rrftag_i;
    logic                    wb1_valid_i, wb2_valid_i, issue_ready_i;
    logic                    issue_valid_o, full_o;
    logic [DATA_LEN-1:0]     issue_src1_o, issue_src2_o;
    logic [ALU_OP_WIDTH-1:0] issue_alu_op_o;
    logic [RRF_SEL-1:0]      issue_rrftag_o;
    logic [3:0]              count_o;

    typedef struct packed {
        logic [DATA_LEN-1:0]     s1;
        logic [DATA_LEN-1:0]     s2;
        logic [ALU_OP_WIDTH-1:0] op;
        logic [RRF_SEL-1:0]      tag;
    } exp_t;

    exp_t expQ[$];
    exp_t obs, want;
    int   testsRun = 0;
    int   testsFailed = 0;

    assign obs = {issue_src1_o, issue_src2_o, issue_alu_op_o, issue_rrftag_o};

    always #5 clk_i = ~clk_i;

    rs_alu_wakeup dut (
        .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i), .dp_we_i(dp_we_i),
        .dp_src1_i(dp_src1_i), .dp_src2_i(dp_src2_i), .dp_rdy1_i(dp_rdy1_i), .dp_rdy2_i(dp_rdy2_i),
        .dp_alu_op_i(dp_alu_op_i), .dp_rrftag_i(dp_rrftag_i),
        .wb1_valid_i(wb1_valid_i), .wb1_rrftag_i(wb1_rrftag_i), .wb1_data_i(wb1_data_i),
        .wb2_valid_i(wb2_valid_i), .wb2_rrftag_i(wb2_rrftag_i), .wb2_data_i(wb2_data_i),
        .issue_ready_i(issue_ready_i), .issue_valid_o(issue_valid_o),
        .issue_src1_o(issue_src1_o), .issue_src2_o(issue_src2_o),
        .issue_alu_op_o(issue_alu_op_o), .issue_rrftag_o(issue_rrftag_o),
        .full_o(full_o), .count_o(count_o)
    );

    // Advance one clock; outputs are sampled 1ns after the active edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idleInputs();
        flush_i = 0; dp_we_i = 0; dp_rdy1_i = 0; dp_rdy2_i = 0;
        dp_src1_i = '0; dp_src2_i = '0; dp_alu_op_i = '0; dp_rrftag_i = '0;
        wb1_valid_i = 0; wb1_rrftag_i = '0; wb1_data_i = '0;
        wb2_valid_i = 0; wb2_rrftag_i = '0; wb2_data_i = '0;
        issue_ready_i = 0;
    endtask

    task automatic doReset();
        idleInputs();
        reset_i = 1;
        tick();
        reset_i = 0;
        expQ.delete();
    endtask

    task automatic dispatch(input logic [DATA_LEN-1:0] s1, input logic r1,
                            input logic [DATA_LEN-1:0] s2, input logic r2,
                            input logic [ALU_OP_WIDTH-1:0] op, input logic [RRF_SEL-1:0] tag);
        dp_we_i = 1; dp_src1_i = s1; dp_rdy1_i = r1; dp_src2_i = s2; dp_rdy2_i = r2;
        dp_alu_op_i = op; dp_rrftag_i = tag;
    endtask

    task automatic test_reset();
        doReset();
        if (issue_valid_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid got %b want 0", issue_valid_o); end
        testsRun++;
        if ({full_o, count_o} !== 5'd0) begin testsFailed++; $display("[TB] FAIL reset_full_count got %b/%0d want 0/0", full_o, count_o); end
        testsRun++;
        if (obs !== '0) begin testsFailed++; $display("[TB] FAIL reset_issue_fields got %h want 0", obs); end
        testsRun++;
    endtask

    task automatic test_dispatch_issue();
        doReset();
        issue_ready_i = 1;
        dispatch(32'd5, 1, 32'd7, 1, ALU_ADD, 6'd3);
        expQ.push_back('{s1: 32'd5, s2: 32'd7, op: ALU_ADD, tag: 6'd3});
        if (issue_valid_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL dp_no_same_cycle got %b want 0", issue_valid_o); end
        testsRun++;
        tick();
        dp_we_i = 0;
        if (issue_valid_o !== 1'b1 || count_o !== 4'd1) begin testsFailed++; $display("[TB] FAIL dp_issue_valid got %b/%0d want 1/1", issue_valid_o, count_o); end
        testsRun++;
        want = (expQ.size() != 0) ? expQ.pop_front() : '0;
        if (obs !== want) begin testsFailed++; $display("[TB] FAIL dp_issue_fields got %h want %h", obs, want); end
        testsRun++;
        tick();
        if (count_o !== 4'd0 || issue_valid_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL dp_release got %0d/%b want 0/0", count_o, issue_valid_o); end
        testsRun++;
    endtask

    task automatic test_wakeup();
        doReset();
        issue_ready_i = 1;
        dispatch(32'hABCD_0009, 0, 32'h22, 1, ALU_SUB, 6'd10);
        expQ.push_back('{s1: 32'hDEAD, s2: 32'h22, op: ALU_SUB, tag: 6'd10});
        tick();
        dp_we_i = 0;
        if (issue_valid_o !== 1'b0 || count_o !== 4'd1) begin testsFailed++; $display("[TB] FAIL wk_waiting got %b/%0d want 0/1", issue_valid_o, count_o); end
        testsRun++;
        tick();
        wb2_valid_i = 1; wb2_rrftag_i = 6'd9; wb2_data_i = 32'hDEAD;
        #1;
        if (issue_valid_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL wk_no_same_cycle got %b want 0", issue_valid_o); end
        testsRun++;
        tick();
        wb2_valid_i = 0;
        want = (expQ.size() != 0) ? expQ.pop_front() : '0;
        if (issue_valid_o !== 1'b1 || obs !== want) begin testsFailed++; $display("[TB] FAIL wk_issue got %b %h want 1 %h", issue_valid_o, obs, want); end
        testsRun++;
        tick();
        // Both buses carry the same tag: bus 1 data must win.
        dispatch(32'd5, 0, 32'h44, 1, ALU_OR, 6'd11);
        expQ.push_back('{s1: 32'hAAAA, s2: 32'h44, op: ALU_OR, tag: 6'd11});
        tick();
        dp_we_i = 0;
        wb1_valid_i = 1; wb1_rrftag_i = 6'd5; wb1_data_i = 32'hAAAA;
        wb2_valid_i = 1; wb2_rrftag_i = 6'd5; wb2_data_i = 32'hBBBB;
        tick();
        wb1_valid_i = 0; wb2_valid_i = 0;
        want = (expQ.size() != 0) ? expQ.pop_front() : '0;
        if (issue_valid_o !== 1'b1 || obs !== want) begin testsFailed++; $display("[TB] FAIL wk_wb1_priority got %b %h want 1 %h", issue_valid_o, obs, want); end
        testsRun++;
        tick();
    endtask

    task automatic test_bypass();
        doReset();
        issue_ready_i = 1;
        dispatch(32'h33, 1, 32'd4, 0, ALU_AND, 6'd12);
        wb1_valid_i = 1; wb1_rrftag_i = 6'd4; wb1_data_i = 32'h11;
        expQ.push_back('{s1: 32'h33, s2: 32'h11, op: ALU_AND, tag: 6'd12});
        tick();
        idleInputs();
        issue_ready_i = 1;
        want = (expQ.size() != 0) ? expQ.pop_front() : '0;
        if (issue_valid_o !== 1'b1 || obs !== want) begin testsFailed++; $display("[TB] FAIL bypass_issue got %b %h want 1 %h", issue_valid_o, obs, want); end
        testsRun++;
        tick();
        if (count_o !== 4'd0) begin testsFailed++; $display("[TB] FAIL bypass_release got %0d want 0", count_o); end
        testsRun++;
    endtask

    task automatic test_full();
        doReset();
        for (int i = 0; i < 8; i++) begin
            dispatch(32'(20 + i), 0, 32'(100 + i), 1, ALU_AND, 6'(i));
            tick();
        end
        if (full_o !== 1'b1 || count_o !== 4'd8 || issue_valid_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_state got %b/%0d/%b want 1/8/0", full_o, count_o, issue_valid_o); end
        testsRun++;
        dispatch(32'hF00, 1, 32'hF01, 1, ALU_ADD, 6'd60);
        tick();
        dp_we_i = 0;
        if (count_o !== 4'd8 || issue_valid_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_drop got %0d/%b want 8/0", count_o, issue_valid_o); end
        testsRun++;
        wb1_valid_i = 1; wb1_rrftag_i = 6'd22; wb1_data_i = 32'h222;
        expQ.push_back('{s1: 32'h222, s2: 32'd102, op: ALU_AND, tag: 6'd2});
        tick();
        wb1_valid_i = 0;
        want = (expQ.size() != 0) ? expQ.pop_front() : '0;
        if (issue_valid_o !== 1'b1 || obs !== want) begin testsFailed++; $display("[TB] FAIL full_entry2_ready got %b %h want 1 %h", issue_valid_o, obs, want); end
        testsRun++;
        issue_ready_i = 1;
        dispatch(32'h55, 1, 32'h66, 1, ALU_OR, 6'd50);
        expQ.push_back('{s1: 32'h55, s2: 32'h66, op: ALU_OR, tag: 6'd50});
        tick();
        if (count_o !== 4'd7 || issue_valid_o !== 1'b0 || full_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_release_alloc got %0d/%b/%b want 7/0/0", count_o, issue_valid_o, full_o); end
        testsRun++;
        tick();
        dp_we_i = 0;
        want = (expQ.size() != 0) ? expQ.pop_front() : '0;
        if (count_o !== 4'd8 || issue_valid_o !== 1'b1 || obs !== want) begin testsFailed++; $display("[TB] FAIL full_refill got %0d %b %h want 8 1 %h", count_o, issue_valid_o, obs, want); end
        testsRun++;
        tick();
        if (count_o !== 4'd7) begin testsFailed++; $display("[TB] FAIL full_refill_release got %0d want 7", count_o); end
        testsRun++;
    endtask

    task automatic test_hold();
        doReset();
        for (int i = 0; i < 6; i++) begin
            if (i == 1 || i == 5) begin
                dispatch(32'(256 + i), 1, 32'(512 + i), 1, ALU_XOR, 6'(i));
                expQ.push_back('{s1: 32'(256 + i), s2: 32'(512 + i), op: ALU_XOR, tag: 6'(i)});
            end else begin
                dispatch(32'(30 + i), 0, 32'd1, 1, ALU_SLL, 6'(i));
            end
            tick();
        end
        dp_we_i = 0;
        for (int c = 0; c < 3; c++) begin
            want = (expQ.size() != 0) ? expQ[0] : '0;
            if (issue_valid_o !== 1'b1 || count_o !== 4'd6 || obs !== want) begin testsFailed++; $display("[TB] FAIL hold_cycle%0d got %b %0d %h want 1 6 %h", c, issue_valid_o, count_o, obs, want); end
            testsRun++;
            tick();
        end
        issue_ready_i = 1;
        want = (expQ.size() != 0) ? expQ.pop_front() : '0;
        if (obs !== want) begin testsFailed++; $display("[TB] FAIL hold_issue_e1 got %h want %h", obs, want); end
        testsRun++;
        tick();
        want = (expQ.size() != 0) ? expQ.pop_front() : '0;
        if (count_o !== 4'd5 || issue_valid_o !== 1'b1 || obs !== want) begin testsFailed++; $display("[TB] FAIL hold_issue_e5 got %0d %b %h want 5 1 %h", count_o, issue_valid_o, obs, want); end
        testsRun++;
        tick();
        if (count_o !== 4'd4 || issue_valid_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL hold_drained got %0d/%b want 4/0", count_o, issue_valid_o); end
        testsRun++;
    endtask

    task automatic test_flush();
        doReset();
        for (int i = 0; i < 6; i++) begin
            dispatch(32'(10 + i), 0, 32'd2, 1, ALU_SRL, 6'(i));
            tick();
        end
        dp_we_i = 0;
        if (count_o !== 4'd6) begin testsFailed++; $display("[TB] FAIL flush_pre_count got %0d want 6", count_o); end
        testsRun++;
        issue_ready_i = 1;
        flush_i = 1;
        dispatch(32'h77, 1, 32'h78, 1, ALU_ADD, 6'd40);
        wb1_valid_i = 1; wb1_rrftag_i = 6'd10; wb1_data_i = 32'h99;
        tick();
        idleInputs();
        issue_ready_i = 1;
        if (count_o !== 4'd0 || issue_valid_o !== 1'b0 || full_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_clear got %0d/%b/%b want 0/0/0", count_o, issue_valid_o, full_o); end
        testsRun++;
        tick();
        if (count_o !== 4'd0 || issue_valid_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_stays_empty got %0d/%b want 0/0", count_o, issue_valid_o); end
        testsRun++;
    endtask

    task automatic test_reset_midflight();
        doReset();
        dispatch(32'h1234, 1, 32'h5678, 1, ALU_SLT, 6'd33);
        tick();
        dispatch(32'd7, 0, 32'd1, 1, ALU_ADD, 6'd34);
        wb2_valid_i = 1; wb2_rrftag_i = 6'd7; wb2_data_i = 32'hCAFE;
        issue_ready_i = 1;
        reset_i = 1;
        tick();
        reset_i = 0;
        idleInputs();
        if (count_o !== 4'd0 || issue_valid_o !== 1'b0 || obs !== '0) begin testsFailed++; $display("[TB] FAIL reset_midflight got %0d %b %h want 0 0 0", count_o, issue_valid_o, obs); end
        testsRun++;
    endtask

    // Run every scenario in sequence, then report.
    initial begin
        reset_i = 0;
        idleInputs();
        test_reset();
        test_dispatch_issue();
        test_wakeup();
        test_bypass();
        test_full();
        test_hold();
        test_flush();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
